// File: rtl/ram_banked_clr.sv
// Banked single-port SRAM with byte-lane writes, registered reads and a
// hardware clear engine that zeroes every row of all banks in parallel.
module ram_banked_clr #(
    parameter int WSIZE          = 4,
    parameter int AW             = 8,
    parameter int BANK_BITS      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN0,
    input  logic [WSIZE-1:0]     WE0,
    input  logic [AW-1:0]        A0,
    input  logic [8*WSIZE-1:0]   Di0,
    output logic [8*WSIZE-1:0]   Do0,
    output logic                 DV0,
    output logic                 RDY,
    input  logic                 CLR
);

    localparam int DW    = 8 * WSIZE;
    localparam int RW    = AW - BANK_BITS;
    localparam int ROWS  = 2 ** RW;
    localparam int BANKS = 2 ** BANK_BITS;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t               state_reg, state_next;
    logic [RW-1:0]        cnt_reg, cnt_next;
    logic                 dv_reg, dv_next;
    logic                 rd_any_reg, rd_any_next;
    logic [BANK_BITS-1:0] sel_reg, sel_next;

    logic [BANK_BITS-1:0] bank;
    logic [RW-1:0]        row;
    logic                 access_ok;
    logic                 do_read;
    logic                 do_write;
    logic                 clear_wr;
    logic [DW-1:0]        bank_rd [BANKS];

    assign bank = A0[AW-1 -: BANK_BITS];
    assign row  = A0[RW-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_reg    <= '0;
            dv_reg     <= 1'b0;
            rd_any_reg <= 1'b0;
            sel_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dv_reg     <= dv_next;
            rd_any_reg <= rd_any_next;
            sel_reg    <= sel_next;
        end
    end

    // A clear request always beats a same-cycle access.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        access_ok   = (state_reg == ST_READY) && !CLR && EN0 && !RST;
        do_write    = access_ok && (WE0 != '0);
        do_read     = access_ok && (WE0 == '0);
        clear_wr    = (state_reg == ST_CLEAR) && !RST;
        dv_next     = do_read;
        rd_any_next = rd_any_reg | do_read;
        sel_next    = do_read ? bank : sel_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (CLR) begin
                    cnt_next = '0;
                end else if (&cnt_reg) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + RW'(1);
                end
            end
            ST_READY: begin
                if (CLR) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        logic [DW-1:0]    mem [ROWS];
        logic [DW-1:0]    rd_reg;
        logic [WSIZE-1:0] lane_we;
        logic [RW-1:0]    addr;
        logic [DW-1:0]    wdata;
        logic             re;
        logic             hit;

        always_comb begin
            hit     = (bank == BANK_BITS'(gi));
            lane_we = '0;
            addr    = row;
            wdata   = Di0;
            re      = 1'b0;
            if (clear_wr) begin
                lane_we = '1;
                addr    = cnt_reg;
                wdata   = '0;
            end else begin
                lane_we = (do_write && hit) ? WE0 : '0;
                re      = do_read && hit;
            end
        end

        // Read register only loads on reads of this bank, so it holds across clears.
        always_ff @(posedge CLK) begin
            for (int i = 0; i < WSIZE; i++) begin
                if (lane_we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (re) begin
                rd_reg <= mem[addr];
            end
        end

        assign bank_rd[gi] = rd_reg;
    end

    assign Do0 = rd_any_reg ? bank_rd[sel_reg] : '0;
    assign DV0 = dv_reg;
    assign RDY = (state_reg == ST_READY);

endmodule

// File: tb/tb_ram_banked_clr.sv
// Directed bench for ram_banked_clr: vector table for single-cycle behaviour,
// hand-written sequences for clear timing, reset mid-clear and a second geometry.
module tb_ram_banked_clr;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
    logic [31:0] dout;
    logic        dv;
    logic        rdy;
    logic        clr;

    logic        rst2;
    logic        en2;
    logic [1:0]  we2;
    logic [9:0]  a2;
    logic [15:0] di2;
    logic [15:0] dout2;
    logic        dv2;
    logic        rdy2;
    logic        clr2;

    int total;
    int passed;

    ram_banked_clr #(.WSIZE(4), .AW(8), .BANK_BITS(1), .CLEAR_ON_RESET(1)) dut (
        .CLK(clk), .RST(rst), .EN0(en), .WE0(we), .A0(a), .Di0(di),
        .Do0(dout), .DV0(dv), .RDY(rdy), .CLR(clr)
    );

    ram_banked_clr #(.WSIZE(2), .AW(10), .BANK_BITS(2), .CLEAR_ON_RESET(0)) dut2 (
        .CLK(clk), .RST(rst2), .EN0(en2), .WE0(we2), .A0(a2), .Di0(di2),
        .Do0(dout2), .DV0(dv2), .RDY(rdy2), .CLR(clr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [7:0]  a;
        logic [31:0] di;
        logic        clr;
        logic [31:0] exp_do;
        logic        exp_dv;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v_en, input logic [3:0] v_we, input logic [7:0] v_a,
                       input logic [31:0] v_di, input logic v_clr, input logic [31:0] v_do,
                       input logic v_dv, input logic v_rdy);
        vec_t v;
        v.en = v_en; v.we = v_we; v.a = v_a; v.di = v_di; v.clr = v_clr;
        v.exp_do = v_do; v.exp_dv = v_dv; v.exp_rdy = v_rdy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; we = '0; a = '0; di = '0; clr = 1'b0;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            en = tbl[k].en; we = tbl[k].we; a = tbl[k].a; di = tbl[k].di; clr = tbl[k].clr;
            step();
            chk($sformatf("vec%0d_do", k), dout, tbl[k].exp_do);
            chk($sformatf("vec%0d_dv", k), {31'b0, dv}, {31'b0, tbl[k].exp_dv});
            chk($sformatf("vec%0d_rdy", k), {31'b0, rdy}, {31'b0, tbl[k].exp_rdy});
            $display("vec %0d: en=%b we=%h a=%h di=%h clr=%b -> do=%h dv=%b rdy=%b",
                     k, tbl[k].en, tbl[k].we, tbl[k].a, tbl[k].di, tbl[k].clr, dout, dv, rdy);
        end
        idle();
    endtask

    // Counts edges until RDY rises; returns 999 if it never does.
    task automatic wait_rdy(output int n);
        n = 0;
        while (!rdy && n < 300) begin
            step();
            n++;
        end
        if (!rdy) n = 999;
    endtask

    initial begin
        int n;
        logic bad;
        total = 0;
        passed = 0;
        rst = 1'b0; rst2 = 1'b0;
        en2 = 1'b0; we2 = '0; a2 = '0; di2 = '0; clr2 = 1'b0;
        idle();

        // T1 vectors 0-1, T2 2-5, T3 6-14, T4 CLR with write 15
        add(1, 4'h0, 8'hFF, 32'h0,        0, 32'h0,        1, 1);
        add(0, 4'h0, 8'h00, 32'h0,        0, 32'h0,        0, 1);
        add(1, 4'hF, 8'h05, 32'hDEADBEEF, 0, 32'h0,        0, 1);
        add(1, 4'h2, 8'h05, 32'h0000A500, 0, 32'h0,        0, 1);
        add(1, 4'h0, 8'h05, 32'h0,        0, 32'hDEADA5EF, 1, 1);
        add(1, 4'h0, 8'h85, 32'h0,        0, 32'h0,        1, 1);
        add(1, 4'hF, 8'h00, 32'h1,        0, 32'h0,        0, 1);
        add(1, 4'hF, 8'h80, 32'h2,        0, 32'h0,        0, 1);
        add(1, 4'h0, 8'h00, 32'h0,        0, 32'h1,        1, 1);
        add(1, 4'h0, 8'h80, 32'h0,        0, 32'h2,        1, 1);
        add(0, 4'h0, 8'h00, 32'h0,        0, 32'h2,        0, 1);
        add(0, 4'h0, 8'h00, 32'h0,        0, 32'h2,        0, 1);
        add(1, 4'hF, 8'h20, 32'h12345678, 0, 32'h2,        0, 1);
        add(1, 4'h0, 8'h20, 32'h0,        0, 32'h12345678, 1, 1);
        add(1, 4'h0, 8'h80, 32'h0,        0, 32'h2,        1, 1);
        add(1, 4'hF, 8'h10, 32'hFFFFFFFF, 1, 32'h2,        0, 0);
        // After clear: 16-19 reads return zero, 20-21 set Do0=55, 22 CLR pulse
        add(1, 4'h0, 8'h10, 32'h0,        0, 32'h0,        1, 1);
        add(1, 4'h0, 8'h30, 32'h0,        0, 32'h0,        1, 1);
        add(1, 4'h0, 8'h05, 32'h0,        0, 32'h0,        1, 1);
        add(1, 4'h0, 8'h80, 32'h0,        0, 32'h0,        1, 1);
        add(1, 4'hF, 8'h40, 32'h55,       0, 32'h0,        0, 1);
        add(1, 4'h0, 8'h40, 32'h0,        0, 32'h55,       1, 1);
        add(0, 4'h0, 8'h00, 32'h0,        1, 32'h55,       0, 0);
        // After reset mid-clear: 23 read, 24 CLR pulse
        add(1, 4'h0, 8'h40, 32'h0,        0, 32'h0,        1, 1);
        add(0, 4'h0, 8'h00, 32'h0,        1, 32'h0,        0, 0);

        #2;
        rst = 1'b1; rst2 = 1'b1;
        #1;
        chk("reset_rdy", {31'b0, rdy}, 32'h0);
        chk("reset_do", dout, 32'h0);
        chk("reset_dv", {31'b0, dv}, 32'h0);
        chk("reset2_rdy", {31'b0, rdy2}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;
        #1;
        chk("release2_rdy", {31'b0, rdy2}, 32'h1);
        wait_rdy(n);
        chk("init_clear_edges", n, 128);
        $display("init clear: rdy after %0d edges", n);

        run_range(0, 16);

        // Accesses during the clear are ignored and must not disturb Do0.
        bad = 1'b0;
        n = 0;
        while (!rdy && n < 300) begin
            en = 1'b1;
            we = n[0] ? 4'hF : 4'h0;
            a  = n[0] ? 8'h30 : 8'h80;
            di = 32'hAAAAAAAA;
            step();
            n++;
            if (dv !== 1'b0 || dout !== 32'h2) bad = 1'b1;
        end
        idle();
        if (!rdy) n = 999;
        chk("clr_request_edges", n, 128);
        chk("clr_access_ignored", {31'b0, bad}, 32'h0);
        $display("clr request: rdy after %0d edges, ignored-access error=%b", n, bad);

        run_range(16, 23);

        repeat (60) step();
        chk("row60_rdy", {31'b0, rdy}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midclear_rst_do", dout, 32'h0);
        chk("midclear_rst_dv", {31'b0, dv}, 32'h0);
        step();
        rst = 1'b0;
        wait_rdy(n);
        chk("rst_midclear_edges", n, 128);
        $display("reset mid-clear: rdy after %0d edges", n);

        run_range(23, 25);

        repeat (100) step();
        chk("row100_rdy", {31'b0, rdy}, 32'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        wait_rdy(n);
        chk("clr_in_clear_edges", n, 128);
        $display("clr at row 100: rdy %0d edges after clr edge", n);

        // Second geometry: no clear on reset, 4 banks, 16-bit words.
        en2 = 1'b1; we2 = 2'b11; a2 = 10'h3FF; di2 = 16'h1234;
        step();
        chk("g2_wr_dv", {31'b0, dv2}, 32'h0);
        en2 = 1'b1; we2 = 2'b00;
        step();
        chk("g2_rd_do", {16'b0, dout2}, 32'h1234);
        chk("g2_rd_dv", {31'b0, dv2}, 32'h1);
        $display("g2 read 3ff: do=%h dv=%b", dout2, dv2);
        we2 = 2'b01; di2 = 16'h00FF;
        step();
        a2 = 10'h000; we2 = 2'b11; di2 = 16'hABCD;
        step();
        a2 = 10'h3FF; we2 = 2'b00;
        step();
        chk("g2_lane_do", {16'b0, dout2}, 32'h12FF);
        $display("g2 read 3ff after lane write: do=%h", dout2);
        a2 = 10'h000;
        step();
        chk("g2_bank0_do", {16'b0, dout2}, 32'hABCD);
        $display("g2 read 000: do=%h", dout2);
        en2 = 1'b0;
        step();
        chk("g2_idle_dv", {31'b0, dv2}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
